// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the 64-bit data memory between the CPU load/store unit (m0)
// and the debug/DMA port (m1), one access at a time, with round-robin arbitration.
module dmem_arbiter #(
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req_valid,
  output logic              m0_req_ready,
  input  logic              m0_req_we,
  input  logic [ADDR_W-1:0] m0_req_addr,
  input  logic [DATA_W-1:0] m0_req_wdata,
  output logic              m0_resp_valid,
  output logic              m0_resp_err,
  output logic [DATA_W-1:0] m0_resp_rdata,
  input  logic              m1_req_valid,
  output logic              m1_req_ready,
  input  logic              m1_req_we,
  input  logic [ADDR_W-1:0] m1_req_addr,
  input  logic [DATA_W-1:0] m1_req_wdata,
  output logic              m1_resp_valid,
  output logic              m1_resp_err,
  output logic [DATA_W-1:0] m1_resp_rdata,
  output logic              mem_MemRead,
  output logic              mem_MemWrite,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              owner_q, owner_d;
  logic              last_grant_q, last_grant_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
  logic              m0_err_q, m0_err_d, m1_err_q, m1_err_d;

  logic              grant, accept, misaligned;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              rsp_load, rsp_tgt, rsp_err;
  logic [DATA_W-1:0] rsp_rdata;

  // On a tie the requester that was not served last time wins.
  always_comb begin
    grant = m1_req_valid;
    if (m0_req_valid && m1_req_valid) grant = ~last_grant_q;
  end

  assign m0_req_ready = (state_q == StIdle) & m0_req_valid & ~grant;
  assign m1_req_ready = (state_q == StIdle) & m1_req_valid & grant;
  assign accept       = m0_req_ready | m1_req_ready;

  assign sel_we     = grant ? m1_req_we    : m0_req_we;
  assign sel_addr   = grant ? m1_req_addr  : m0_req_addr;
  assign sel_wdata  = grant ? m1_req_wdata : m0_req_wdata;
  assign misaligned = sel_addr[2:0] != 3'd0;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rsp_load     = 1'b0;
    rsp_tgt      = owner_q;
    rsp_err      = 1'b0;
    rsp_rdata    = '0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          owner_d      = grant;
          last_grant_d = grant;
          we_d         = sel_we;
          addr_d       = sel_addr;
          wdata_d      = sel_wdata;
          if (misaligned) begin
            // Misaligned requests skip the memory entirely.
            state_d  = StResp;
            rsp_load = 1'b1;
            rsp_tgt  = grant;
            rsp_err  = 1'b1;
          end else begin
            state_d = StBusy;
            cnt_d   = 4'(LATENCY);
          end
        end
      end
      StBusy: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d   = StResp;
          rsp_load  = 1'b1;
          rsp_rdata = we_q ? '0 : mem_read_data;
        end
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Response data and error flag are held per requester until its next response.
  always_comb begin
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    m0_err_d   = m0_err_q;
    m1_err_d   = m1_err_q;
    if (rsp_load) begin
      if (rsp_tgt) begin
        m1_rdata_d = rsp_rdata;
        m1_err_d   = rsp_err;
      end else begin
        m0_rdata_d = rsp_rdata;
        m0_err_d   = rsp_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= 4'd0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
      m0_err_q     <= 1'b0;
      m1_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
      m0_err_q     <= m0_err_d;
      m1_err_q     <= m1_err_d;
    end
  end

  assign mem_MemRead    = (state_q == StBusy) & ~we_q;
  assign mem_MemWrite   = (state_q == StBusy) & we_q;
  assign mem_address    = (state_q == StBusy) ? addr_q  : '0;
  assign mem_write_data = (state_q == StBusy) ? wdata_q : '0;

  assign m0_resp_valid = (state_q == StResp) & ~owner_q;
  assign m1_resp_valid = (state_q == StResp) & owner_q;
  assign m0_resp_rdata = m0_rdata_q;
  assign m1_resp_rdata = m1_rdata_q;
  assign m0_resp_err   = m0_err_q;
  assign m1_resp_err   = m1_err_q;

endmodule
